// File: rtl/floor_sched_pkg.sv
// floor_sched_pkg
// Shared types, constants and floor-mask helpers for floor_request_scheduler.
// Floor vectors are handled at MAX_FLOORS width inside the helpers; callers
// zero-extend their NUM_FLOORS-wide vectors and truncate the results.
// No ports (package).
package floor_sched_pkg;

  localparam int unsigned NUM_FLOORS_DEFAULT = 4;
  localparam int unsigned MAX_FLOORS         = 32;
  // Wide enough for a dwell of up to 15 ticks.
  localparam int unsigned DWELL_W            = 4;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR
  } sched_state_e;

  typedef logic [MAX_FLOORS-1:0] floor_mask_t;

  function automatic logic is_onehot(input floor_mask_t v);
    return (v != '0) && ((v & (v - floor_mask_t'(1))) == '0);
  endfunction

  // One-hot of the lowest set bit of mask strictly above the bit set in onehot.
  // Returns zero when no such bit exists.
  function automatic floor_mask_t lowest_above(input floor_mask_t mask,
                                               input floor_mask_t onehot);
    floor_mask_t res;
    logic        seen;
    logic        found;
    res   = '0;
    seen  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (seen && mask[i] && !found) begin
        res[i] = 1'b1;
        found  = 1'b1;
      end
      if (onehot[i]) seen = 1'b1;
    end
    return res;
  endfunction

  // One-hot of the highest set bit of mask strictly below the bit set in onehot.
  // Returns zero when no such bit exists.
  function automatic floor_mask_t highest_below(input floor_mask_t mask,
                                                input floor_mask_t onehot);
    floor_mask_t res;
    logic        seen;
    logic        found;
    res   = '0;
    seen  = 1'b0;
    found = 1'b0;
    for (int i = MAX_FLOORS - 1; i >= 0; i--) begin
      if (seen && mask[i] && !found) begin
        res[i] = 1'b1;
        found  = 1'b1;
      end
      if (onehot[i]) seen = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/floor_request_scheduler_button_edge_sync.sv
// button_edge_sync
// Two-flop synchroniser for one raw call button followed by a rising-edge
// detector. The pulse is high for one cycle, two clocks after the raw rise,
// so the pending bit it sets becomes visible three cycles after the rise.
// Ports:
//   clk    in   clock
//   reset  in   asynchronous, active-high reset
//   btn    in   raw asynchronous button level
//   pulse  out  one-cycle pulse on a synchronised rising edge
module button_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse = sync_q & ~prev_q;

endmodule

// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler
// Latches synchronised call buttons into a pending set, runs a collective
// up/down sweep with a door dwell, and drives a one-hot target floor into the
// floor-stepping controller. Arrivals are detected from the controller's
// one-hot present floor.
// Optional feature: define FLOOR_REQUEST_SERVICE_LOCK_EN to add svc_lock_i,
// which flushes requests and sends the car to floor 0.
// Ports:
//   clk              in   clock
//   reset            in   asynchronous, active-high reset
//   tick_i           in   1 Hz single-cycle tick shared with the controller
//   call_btn_i       in   raw call buttons, bit n = floor n
//   present_floor_i  in   one-hot present floor from the controller
//   svc_lock_i       in   service lock (only with FLOOR_REQUEST_SERVICE_LOCK_EN)
//   target_floor_o   out  one-hot target floor (registered)
//   pending_o        out  latched outstanding requests
//   door_open_o      out  door held open at a served floor (registered)
//   dir_up_o         out  current / last sweep direction, 1 = up
//   busy_o           out  not idle (registered)
module floor_request_scheduler
  import floor_sched_pkg::*;
#(
  parameter int unsigned NUM_FLOORS  = NUM_FLOORS_DEFAULT,
  parameter int unsigned DWELL_TICKS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick_i,
  input  logic [NUM_FLOORS-1:0] call_btn_i,
  input  logic [NUM_FLOORS-1:0] present_floor_i,
`ifdef FLOOR_REQUEST_SERVICE_LOCK_EN
  input  logic                  svc_lock_i,
`endif
  output logic [NUM_FLOORS-1:0] target_floor_o,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic                  door_open_o,
  output logic                  dir_up_o,
  output logic                  busy_o
);

  typedef logic [NUM_FLOORS-1:0] fvec_t;

  localparam fvec_t              FloorZero  = fvec_t'(1);
  localparam logic [DWELL_W-1:0] DwellLoad  = DWELL_W'(DWELL_TICKS);

  sched_state_e       state_q, state_d;
  fvec_t              pending_q, pending_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               dir_q, dir_d;
  fvec_t              target_q, target_d;
  logic               door_q, door_d;
  logic               busy_q, busy_d;

  fvec_t btn_edge;
  fvec_t edge_mask;
  fvec_t clear;
  fvec_t up_pick;
  fvec_t dn_pick;
  logic  present_ok;
  logic  any_above;
  logic  any_below;
  logic  arr;
  logic  lock_active;
  logic  lock_release;

  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    button_edge_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .btn   (call_btn_i[g]),
      .pulse (btn_edge[g])
    );
  end

`ifdef FLOOR_REQUEST_SERVICE_LOCK_EN
  logic lock_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_q <= 1'b0;
    else       lock_q <= svc_lock_i;
  end

  assign lock_active  = svc_lock_i;
  assign lock_release = lock_q & ~svc_lock_i;
`else
  assign lock_active  = 1'b0;
  assign lock_release = 1'b0;
`endif

  assign present_ok = is_onehot(floor_mask_t'(present_floor_i));
  assign up_pick    = fvec_t'(lowest_above(floor_mask_t'(pending_q),
                                           floor_mask_t'(present_floor_i)));
  assign dn_pick    = fvec_t'(highest_below(floor_mask_t'(pending_q),
                                            floor_mask_t'(present_floor_i)));
  assign any_above  = |up_pick;
  assign any_below  = |dn_pick;
  // A malformed present floor is treated as "no arrival".
  assign arr        = present_ok & (|(present_floor_i & pending_q));

  // Next state, pending set, dwell and direction.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    dwell_d   = dwell_q;
    clear     = '0;
    edge_mask = btn_edge;

    // A call for the floor we are dwelling at only extends the dwell.
    if (state_q == DOOR) edge_mask = btn_edge & ~present_floor_i;

    // Everything except request latching freezes on a non-one-hot floor.
    if (present_ok) begin
      unique case (state_q)
        IDLE: begin
          if (arr) begin
            state_d = DOOR;
            clear   = present_floor_i;
            dwell_d = DwellLoad;
          end else if (any_above) begin
            state_d = MOVE_UP;
            dir_d   = 1'b1;
          end else if (any_below) begin
            state_d = MOVE_DOWN;
            dir_d   = 1'b0;
          end
        end
        MOVE_UP: begin
          if (arr) begin
            state_d = DOOR;
            clear   = present_floor_i;
            dwell_d = DwellLoad;
          end else if (!any_above) begin
            if (any_below) begin
              state_d = MOVE_DOWN;
              dir_d   = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        MOVE_DOWN: begin
          if (arr) begin
            state_d = DOOR;
            clear   = present_floor_i;
            dwell_d = DwellLoad;
          end else if (!any_below) begin
            if (any_above) begin
              state_d = MOVE_UP;
              dir_d   = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        DOOR: begin
          if (|(btn_edge & present_floor_i)) begin
            dwell_d = DwellLoad;
          end else if (tick_i) begin
            if (dwell_q == '0) begin
              // Collective sweep: keep going, else reverse, else rest.
              if (dir_q && any_above) begin
                state_d = MOVE_UP;
              end else if (!dir_q && any_below) begin
                state_d = MOVE_DOWN;
              end else if (any_above) begin
                state_d = MOVE_UP;
                dir_d   = 1'b1;
              end else if (any_below) begin
                state_d = MOVE_DOWN;
                dir_d   = 1'b0;
              end else begin
                state_d = IDLE;
              end
            end else begin
              dwell_d = dwell_q - DWELL_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear is applied after the OR so a same-cycle edge elsewhere survives.
    pending_d = (pending_q | edge_mask) & ~clear;

    if (lock_release) state_d = IDLE;

    if (lock_active) begin
      pending_d = '0;
      dwell_d   = '0;
      if (present_floor_i == FloorZero) begin
        state_d = IDLE;
      end else begin
        state_d = MOVE_DOWN;
        dir_d   = 1'b0;
      end
    end
  end

  // Registered outputs derived from the current state; they trail it by a cycle.
  always_comb begin
    target_d = target_q;
    if (present_ok) begin
      unique case (state_q)
        MOVE_UP:   target_d = any_above ? up_pick : present_floor_i;
        MOVE_DOWN: target_d = any_below ? dn_pick : present_floor_i;
        default:   target_d = present_floor_i;
      endcase
    end
    door_d = (state_q == DOOR);
    busy_d = (state_q != IDLE);
    if (lock_active) begin
      target_d = FloorZero;
      door_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      dwell_q   <= '0;
      dir_q     <= 1'b1;
      target_q  <= FloorZero;
      door_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dwell_q   <= dwell_d;
      dir_q     <= dir_d;
      target_q  <= target_d;
      door_q    <= door_d;
      busy_q    <= busy_d;
    end
  end

  assign target_floor_o = target_q;
  assign pending_o      = pending_q;
  assign door_open_o    = door_q;
  assign dir_up_o       = dir_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// tb_floor_request_scheduler
// Directed bench for floor_request_scheduler with NUM_FLOORS = 4 and
// DWELL_TICKS = 3. The bench plays the controller by driving present_floor_i.
module tb_floor_request_scheduler;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [3:0] call;
  logic [3:0] present;
  logic [3:0] target;
  logic [3:0] pending;
  logic       door;
  logic       dir_up;
  logic       busy;
`ifdef FLOOR_REQUEST_SERVICE_LOCK_EN
  logic       svc_lock;
`endif

  int checks = 0;
  int errors = 0;

  floor_request_scheduler #(
    .NUM_FLOORS  (4),
    .DWELL_TICKS (3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .tick_i          (tick),
    .call_btn_i      (call),
    .present_floor_i (present),
`ifdef FLOOR_REQUEST_SERVICE_LOCK_EN
    .svc_lock_i      (svc_lock),
`endif
    .target_floor_o  (target),
    .pending_o       (pending),
    .door_open_o     (door),
    .dir_up_o        (dir_up),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic press(input logic [3:0] mask);
    call = mask;
    repeat (3) step();
    call = 4'b0000;
  endtask

  task automatic check_v(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    call    = 4'b0000;
    present = 4'b0001;
`ifdef FLOOR_REQUEST_SERVICE_LOCK_EN
    svc_lock = 1'b0;
`endif
    repeat (2) step();
    check_v("rst_target", target, 4'b0001);
    check_v("rst_pending", pending, 4'b0000);
    check_b("rst_door", door, 1'b0);
    check_b("rst_dir", dir_up, 1'b1);
    check_b("rst_busy", busy, 1'b0);
    reset = 1'b0;
    step();

    // Floor 0, call floor 2: latch latency, sweep up, serve, dwell, idle.
    call = 4'b0100;
    step();
    step();
    check_v("a_pend_sync", pending, 4'b0000);
    step();
    check_v("a_pend_set", pending, 4'b0100);
    call = 4'b0000;
    step();
    check_b("a_busy_lag", busy, 1'b0);
    check_b("a_dir", dir_up, 1'b1);
    step();
    check_v("a_target", target, 4'b0100);
    check_b("a_busy", busy, 1'b1);
    present = 4'b0010;
    step();
    step();
    check_v("a_target_f1", target, 4'b0100);
    present = 4'b0100;
    step();
    check_v("a_clear", pending, 4'b0000);
    check_b("a_door_lag", door, 1'b0);
    step();
    check_b("a_door", door, 1'b1);
    check_v("a_door_target", target, 4'b0100);
    repeat (3) tick_pulse();
    check_b("a_door_3ticks", door, 1'b1);
    tick_pulse();
    check_b("a_door_closed", door, 1'b0);
    check_b("a_idle", busy, 1'b0);

    // Floor 1 heading to floor 3; a call for floor 2 retargets.
    present = 4'b0010;
    step();
    step();
    check_v("b_idle_target", target, 4'b0010);
    press(4'b1000);
    check_v("b_pend3", pending, 4'b1000);
    step();
    step();
    check_v("b_target3", target, 4'b1000);
    press(4'b0100);
    check_v("b_pend23", pending, 4'b1100);
    check_v("b_target_before", target, 4'b1000);
    step();
    check_v("b_retarget", target, 4'b0100);
    present = 4'b0100;
    step();
    check_v("b_clear2", pending, 4'b1000);
    step();
    check_b("b_door", door, 1'b1);
    repeat (4) tick_pulse();
    check_v("b_continue", target, 4'b1000);
    check_b("b_door_closed", door, 1'b0);
    check_b("b_dir", dir_up, 1'b1);

    // Floor 2 moving up with 3 and 0 pending: serve 3, then reverse.
    press(4'b0001);
    check_v("c_pend", pending, 4'b1001);
    present = 4'b1000;
    step();
    check_v("c_clear3", pending, 4'b0001);
    step();
    check_b("c_door", door, 1'b1);
    repeat (4) tick_pulse();
    check_b("c_dir_down", dir_up, 1'b0);
    check_v("c_target0", target, 4'b0001);
    check_b("c_busy", busy, 1'b1);
    present = 4'b0001;
    step();
    step();
    check_b("c_door0", door, 1'b1);
    check_v("c_clear0", pending, 4'b0000);
    repeat (4) tick_pulse();
    check_b("c_idle", busy, 1'b0);

    // Door at floor 1: a press for floor 1 at dwell 1 reloads the dwell.
    present = 4'b0010;
    step();
    press(4'b0010);
    check_v("d_pend", pending, 4'b0010);
    step();
    check_v("d_clear", pending, 4'b0000);
    step();
    check_b("d_door", door, 1'b1);
    repeat (2) tick_pulse();
    press(4'b0010);
    check_v("d_no_latch", pending, 4'b0000);
    repeat (3) tick_pulse();
    check_b("d_reload", door, 1'b1);
    tick_pulse();
    check_b("d_door_closed", door, 1'b0);

    // Non-one-hot present floor: no arrival, state and target hold.
    press(4'b0100);
    check_v("e_pend", pending, 4'b0100);
    step();
    step();
    check_v("e_target", target, 4'b0100);
    present = 4'b0110;
    repeat (3) step();
    check_v("e_hold_pend", pending, 4'b0100);
    check_v("e_hold_target", target, 4'b0100);
    check_b("e_hold_busy", busy, 1'b1);
    check_b("e_hold_door", door, 1'b0);
    present = 4'b0100;
    step();
    check_v("e_clear", pending, 4'b0000);
    step();
    check_b("e_door", door, 1'b1);
    repeat (4) tick_pulse();
    check_b("e_idle", busy, 1'b0);

    // A held button latches once only.
    call = 4'b0100;
    repeat (3) step();
    check_v("g_pend", pending, 4'b0100);
    step();
    check_v("g_clear", pending, 4'b0000);
    step();
    check_b("g_door", door, 1'b1);
    repeat (4) tick_pulse();
    check_v("g_held_once", pending, 4'b0000);
    check_b("g_idle", busy, 1'b0);
    call = 4'b0000;
    step();

    // Reset in the middle of a dwell with other requests outstanding.
    press(4'b0100);
    step();
    step();
    check_b("f_door", door, 1'b1);
    press(4'b1010);
    check_v("f_pend", pending, 4'b1010);
    reset = 1'b1;
    step();
    check_v("f_rst_pending", pending, 4'b0000);
    check_v("f_rst_target", target, 4'b0001);
    check_b("f_rst_door", door, 1'b0);
    check_b("f_rst_busy", busy, 1'b0);
    reset = 1'b0;
    step();

`ifdef FLOOR_REQUEST_SERVICE_LOCK_EN
    // Service lock at floor 2 with floor 3 pending.
    present = 4'b0100;
    step();
    step();
    press(4'b1000);
    step();
    check_v("lk_pend", pending, 4'b1000);
    svc_lock = 1'b1;
    step();
    check_v("lk_flush", pending, 4'b0000);
    check_v("lk_target", target, 4'b0001);
    check_b("lk_door", door, 1'b0);
    press(4'b0010);
    step();
    check_v("lk_ignore", pending, 4'b0000);
    present = 4'b0001;
    step();
    step();
    svc_lock = 1'b0;
    step();
    step();
    check_v("lk_rel_pend", pending, 4'b0000);
    check_b("lk_rel_busy", busy, 1'b0);
    check_v("lk_rel_target", target, 4'b0001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
